config_sequencer: RTL and testbench

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/config_sequencer.sv | 178 +++++++++++++++++
 tb/tb_config_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/config_sequencer.sv
// Config sequencer: reads a table of words from a registered ROM and offers each one
// to a downstream writer over a valid/ready handshake. Define CFG_SEQ_TIMEOUT_EN to
// add a handshake watchdog.
module config_sequencer #(
  parameter int NUM_WORDS      = 8,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 24,
  parameter int SETTLE_CYCLES  = 50,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  if (NUM_WORDS < 1 || NUM_WORDS > 256 || SETTLE_CYCLES < 0 || TIMEOUT_CYCLES < 1 ||
      (NUM_WORDS > 1 && $clog2(NUM_WORDS) > ADDR_W)) begin : g_bad_params
    $error("config_sequencer: illegal parameter combination");
  end

  // A settle of 0 or 1 cycles both collapse to a single SETTLE cycle.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = (SETTLE_CYCLES > 1) ? SET_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, REQ, SETTLE, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            error_q, error_d;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    rom_addr_d   = rom_addr_q;
    wr_data_d    = wr_data_q;
    wr_valid_d   = wr_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
`ifdef CFG_SEQ_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    error_d      = error_q;
`endif

    case (state_q)
      // busy is low only in these three states, so start is ignored elsewhere.
      IDLE, DONE, ERROR: begin
        if (start) begin
          idx_d      = '0;
          rom_addr_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
          error_d    = 1'b0;
`endif
          state_d    = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        wr_data_d  = rom_data;
        wr_valid_d = 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        state_d    = REQ;
      end
      REQ: begin
        // wr_valid is always high in REQ, so wr_ready alone completes the handshake.
        if (wr_ready) begin
          wr_valid_d   = 1'b0;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
`ifdef CFG_SEQ_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          wr_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b0;
          error_d    = 1'b1;
          state_d    = ERROR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d      = idx_q + 1'b1;
            rom_addr_d = idx_q + 1'b1;
            state_d    = FETCH;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      rom_addr_q   <= '0;
      wr_data_q    <= '0;
      wr_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      rom_addr_q   <= rom_addr_d;
      wr_data_q    <= wr_data_d;
      wr_valid_q   <= wr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef CFG_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign rom_addr = rom_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_config_sequencer.sv
// Randomized self-checking bench for config_sequencer: a table-driven model of the
// expected word order, handshake timing and status flags.
module tb_config_sequencer;
  localparam int NW = 4;
  localparam int AW = 8;
  localparam int DW = 24;
  localparam int S  = 3;
  localparam int TO = 16;
  localparam int SE = (S < 1) ? 1 : S;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic          error;

  logic [DW-1:0] rom [0:255];
  int tests_run    = 0;
  int tests_failed = 0;

  config_sequencer #(
    .NUM_WORDS(NW), .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .busy(busy),
    .done(done), .error(error)
  );

  always #10 clk = ~clk;

  // Registered ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_wr_data"},  32'(wr_data),  32'd0);
    check({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_error"},    32'(error),    32'd0);
  endtask

  // Counts negedges until the selected flag is high (0: wr_valid, 1: done, 2: error).
  task automatic wait_flag(input int which, input string tag, output int n);
    logic s;
    n = 0;
    s = 1'b0;
    while (n < 500 && !s) begin
      @(negedge clk);
      n++;
      s = (which == 0) ? wr_valid : (which == 1) ? done : error;
    end
    if (!s) check({tag, "_wait_expired"}, 32'd0, 32'd1);
  endtask

  task automatic run_sequence(input bit directed, input int abort_at);
    int n;
    int stall;
    for (int i = 0; i < NW; i++)
      rom[i] = directed ? DW'(32'hA1 + 32'h11 * i) : DW'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",  32'(busy),  32'd1);
    check("start_done",  32'(done),  32'd0);
    check("start_error", 32'(error), 32'd0);
    wait_flag(0, "first_valid", n);
    check("first_latency", 32'(n), 32'd2);
    for (int i = 0; i < NW; i++) begin
      check("word_addr",  32'(rom_addr), 32'(i));
      check("word_data",  32'(wr_data),  32'(rom[i]));
      check("word_valid", 32'(wr_valid), 32'd1);
      stall = directed ? ((i == 1) ? 10 : 0) : int'($urandom_range(0, 4));
      if (i == 2) begin
        if (stall < 1) stall = 1;
        start = 1'b1;
      end
      $display("[TB] word %0d addr %0d data %h stall %0d", i, rom_addr, wr_data, stall);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        start = 1'b0;
        check("stall_valid", 32'(wr_valid), 32'd1);
        check("stall_data",  32'(wr_data),  32'(rom[i]));
        check("stall_addr",  32'(rom_addr), 32'(i));
        check("stall_busy",  32'(busy),     32'd1);
      end
      wr_ready = 1'b1;
      @(negedge clk);
      wr_ready = 1'b0;
      start = 1'b0;
      check("accept_valid", 32'(wr_valid), 32'd0);
      if (abort_at == i) begin
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("post_reset_valid", 32'(wr_valid), 32'd0);
          check("post_reset_busy",  32'(busy),     32'd0);
        end
        return;
      end
      if (i < NW - 1) begin
        wait_flag(0, "next_valid", n);
        check("word_gap", 32'(n), 32'(SE + 2));
      end else begin
        wait_flag(1, "done", n);
        check("done_latency", 32'(n), 32'(SE));
        check("done_busy",    32'(busy),     32'd0);
        check("done_valid",   32'(wr_valid), 32'd0);
        check("done_error",   32'(error),    32'd0);
      end
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Start together with reset must lose.
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_valid", 32'(wr_valid), 32'd0);
    end

    run_sequence(1'b1, -1);
    run_sequence(1'b0, -1);
    run_sequence(1'b0, 2);
    run_sequence(1'b0, -1);

`ifdef CFG_SEQ_TIMEOUT_EN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_flag(0, "to_valid", n);
    check("to_first_latency", 32'(n), 32'd2);
    wait_flag(2, "timeout", n);
    $display("[TB] timeout after %0d REQ cycles", n);
    check("to_cycles", 32'(n),        32'(TO));
    check("to_valid",  32'(wr_valid), 32'd0);
    check("to_busy",   32'(busy),     32'd0);
    check("to_done",   32'(done),     32'd0);
    run_sequence(1'b0, -1);
`endif

    repeat (3) run_sequence(1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
